// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception codes, the default exception vector,
// the commit-point scheduler state encoding and the exception bundle type.
package cpu_defs;

  localparam logic [4:0]  EXCCODE_INT        = 5'h00;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIR
  } exc_sched_state_e;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] badvaddr;
  } exception_t;

endpackage

// File: rtl/exc_sched.sv
// Commit-point exception/interrupt scheduler.
// Picks one event per WB commit slot (interrupt > exception > ERET), pulses
// CP0 for one cycle, holds flush for FLUSH_CYCLES cycles, then presents a
// valid/ready redirect to fetch. Commits are blocked until it is accepted.
// Optional: define EXC_SCHED_STAT_EN to add exc_count/eret_count outputs.
module exc_sched
  import cpu_defs::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_exccode,
  input  logic        ws_bd,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic [31:0] ws_pc,
  input  logic [7:0]  int_pending,
  input  logic [31:0] epc,
  output logic        commit_ok,
  output logic        c0_ex,
  output logic [4:0]  c0_exccode,
  output logic        c0_bd,
  output logic [31:0] c0_badvaddr,
  output logic [31:0] c0_pc,
  output logic        c0_eret,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
`ifdef EXC_SCHED_STAT_EN
  ,
  output logic [31:0] exc_count,
  output logic [31:0] eret_count
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  exc_sched_state_e state_q, state_d;
  logic [3:0]       flushCnt_q, flushCnt_d;
  logic [31:0]      redirPc_q, redirPc_d;

  logic       intEvt, excEvt, eretEvt;
  exception_t evtSel;

  // Event priority: a pending interrupt beats an exception, which beats ERET.
  always_comb begin
    intEvt  = ws_valid && (int_pending != 8'h00);
    excEvt  = ws_valid && !intEvt && ws_ex;
    eretEvt = ws_valid && !intEvt && !ws_ex && ws_eret;
    evtSel  = '0;
    if (intEvt) begin
      evtSel.ex      = 1'b1;
      evtSel.exccode = EXCCODE_INT;
      evtSel.bd      = ws_bd;
    end else if (excEvt) begin
      evtSel.ex       = 1'b1;
      evtSel.exccode  = ws_exccode;
      evtSel.bd       = ws_bd;
      evtSel.badvaddr = ws_badvaddr;
    end
  end

  // Next-state and output decode for the IDLE/FLUSH/REDIR sequence.
  always_comb begin
    state_d     = state_q;
    flushCnt_d  = flushCnt_q;
    redirPc_d   = redirPc_q;
    commit_ok   = 1'b0;
    c0_ex       = 1'b0;
    c0_exccode  = 5'h00;
    c0_bd       = 1'b0;
    c0_badvaddr = 32'h0;
    c0_pc       = 32'h0;
    c0_eret     = 1'b0;
    flush       = 1'b0;
    redir_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (evtSel.ex || eretEvt) begin
          c0_ex       = evtSel.ex;
          c0_exccode  = evtSel.exccode;
          c0_bd       = evtSel.bd;
          c0_badvaddr = evtSel.badvaddr;
          c0_pc       = evtSel.ex ? ws_pc : 32'h0;
          c0_eret     = eretEvt;
          redirPc_d   = eretEvt ? epc : EXC_VECTOR;
          flushCnt_d  = FLUSH_LOAD;
          state_d     = FLUSH;
        end else begin
          commit_ok = 1'b1;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (flushCnt_q <= 4'd1) begin
          flushCnt_d = 4'd0;
          state_d    = REDIR;
        end else begin
          flushCnt_d = flushCnt_q - 4'd1;
        end
      end
      REDIR: begin
        redir_valid = 1'b1;
        if (redir_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign redir_pc = redirPc_q;

  // State, flush counter and redirect target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      flushCnt_q <= 4'd0;
      redirPc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
      redirPc_q  <= redirPc_d;
    end
  end

`ifdef EXC_SCHED_STAT_EN
  logic [31:0] excCount_q, eretCount_q;

  // Event statistics; both counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      excCount_q  <= 32'h0;
      eretCount_q <= 32'h0;
    end else begin
      if (c0_ex)   excCount_q  <= excCount_q + 32'd1;
      if (c0_eret) eretCount_q <= eretCount_q + 32'd1;
    end
  end

  assign exc_count  = excCount_q;
  assign eret_count = eretCount_q;
`endif

endmodule

// File: tb/tb_exc_sched.sv
// Directed testbench for exc_sched (FLUSH_CYCLES=2, default vector).
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further unit later, well away from the next edge.
module tb_exc_sched;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_ex, ws_bd, ws_eret;
  logic [4:0]  ws_exccode;
  logic [31:0] ws_badvaddr, ws_pc, epc;
  logic [7:0]  int_pending;
  logic        commit_ok, c0_ex, c0_bd, c0_eret, flush, redir_valid, redir_ready;
  logic [4:0]  c0_exccode;
  logic [31:0] c0_badvaddr, c0_pc, redir_pc;
`ifdef EXC_SCHED_STAT_EN
  logic [31:0] exc_count, eret_count;
`endif

  int errors = 0;
  int checks = 0;

  exc_sched #(.FLUSH_CYCLES(2), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset),
    .ws_valid(ws_valid), .ws_ex(ws_ex), .ws_exccode(ws_exccode), .ws_bd(ws_bd),
    .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret), .ws_pc(ws_pc),
    .int_pending(int_pending), .epc(epc),
    .commit_ok(commit_ok), .c0_ex(c0_ex), .c0_exccode(c0_exccode), .c0_bd(c0_bd),
    .c0_badvaddr(c0_badvaddr), .c0_pc(c0_pc), .c0_eret(c0_eret),
    .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready)
`ifdef EXC_SCHED_STAT_EN
    , .exc_count(exc_count), .eret_count(eret_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic clearInputs();
    ws_valid = 0; ws_ex = 0; ws_exccode = 0; ws_bd = 0; ws_badvaddr = 0;
    ws_eret = 0; ws_pc = 0; int_pending = 0; epc = 0; redir_ready = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    clearInputs();
    stepCycle();
    stepCycle();
    reset = 0;
    #1;
    checks++; if (commit_ok !== 1'b1) begin errors++; $display("[TB] FAIL reset_commit_ok got=%b want=1", commit_ok); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got=%b want=0", flush); end
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_redir_valid got=%b want=0", redir_valid); end
    checks++; if (redir_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_redir_pc got=%h want=0", redir_pc); end
    checks++; if ({c0_ex, c0_eret} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses got=%b want=00", {c0_ex, c0_eret}); end
`ifdef EXC_SCHED_STAT_EN
    checks++; if (exc_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_exc_count got=%h want=0", exc_count); end
`endif
  endtask

  task automatic test_exception();
    stepCycle();
    ws_valid = 1; ws_ex = 1; ws_exccode = 5'h04; ws_pc = 32'h8000_0100;
    ws_badvaddr = 32'h1234_5679; ws_bd = 1;
    #1;
    checks++; if (c0_ex !== 1'b1) begin errors++; $display("[TB] FAIL exc_pulse got=%b want=1", c0_ex); end
    checks++; if (c0_exccode !== 5'h04) begin errors++; $display("[TB] FAIL exc_code got=%h want=04", c0_exccode); end
    checks++; if (c0_pc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL exc_pc got=%h want=80000100", c0_pc); end
    checks++; if (c0_badvaddr !== 32'h1234_5679) begin errors++; $display("[TB] FAIL exc_badvaddr got=%h want=12345679", c0_badvaddr); end
    checks++; if (c0_bd !== 1'b1) begin errors++; $display("[TB] FAIL exc_bd got=%b want=1", c0_bd); end
    checks++; if ({commit_ok, c0_eret} !== 2'b00) begin errors++; $display("[TB] FAIL exc_commit_eret got=%b want=00", {commit_ok, c0_eret}); end
    stepCycle();
    clearInputs();
    #1;
    checks++; if ({flush, redir_valid, c0_ex} !== 3'b100) begin errors++; $display("[TB] FAIL exc_flush1 got=%b want=100", {flush, redir_valid, c0_ex}); end
    stepCycle();
    checks++; if ({flush, redir_valid} !== 2'b10) begin errors++; $display("[TB] FAIL exc_flush2 got=%b want=10", {flush, redir_valid}); end
    stepCycle();
    checks++; if ({flush, redir_valid} !== 2'b01) begin errors++; $display("[TB] FAIL exc_redir got=%b want=01", {flush, redir_valid}); end
    checks++; if (redir_pc !== VEC) begin errors++; $display("[TB] FAIL exc_redir_pc got=%h want=%h", redir_pc, VEC); end
`ifdef EXC_SCHED_STAT_EN
    checks++; if (exc_count !== 32'd1) begin errors++; $display("[TB] FAIL exc_count got=%0d want=1", exc_count); end
`endif
  endtask

  // Continues from REDIR left by test_exception.
  task automatic test_redir_stall();
    redir_ready = 0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checks++;
      if ({redir_valid, commit_ok, flush} !== 3'b100 || redir_pc !== VEC) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d got v/ok/fl=%b pc=%h want 100 pc=%h", i, {redir_valid, commit_ok, flush}, redir_pc, VEC);
      end
    end
    redir_ready = 1;
    #1;
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_xfer_valid got=%b want=1", redir_valid); end
    stepCycle();
    redir_ready = 0;
    #1;
    checks++; if ({redir_valid, commit_ok} !== 2'b01) begin errors++; $display("[TB] FAIL stall_idle got=%b want=01", {redir_valid, commit_ok}); end
  endtask

  task automatic test_eret();
    ws_valid = 1; ws_eret = 1; epc = 32'h8000_2004;
    #1;
    checks++; if ({c0_eret, c0_ex, commit_ok} !== 3'b100) begin errors++; $display("[TB] FAIL eret_pulse got=%b want=100", {c0_eret, c0_ex, commit_ok}); end
    stepCycle();
    clearInputs();
    epc = 32'hDEAD_BEEF;
    stepCycle();
    stepCycle();
    checks++; if ({redir_valid, redir_pc} !== {1'b1, 32'h8000_2004}) begin errors++; $display("[TB] FAIL eret_redir got v=%b pc=%h want v=1 pc=80002004", redir_valid, redir_pc); end
    redir_ready = 1;
    stepCycle();
    redir_ready = 0;
  endtask

  task automatic test_eret_int();
    ws_valid = 1; ws_eret = 1; int_pending = 8'h80; epc = 32'h8000_3000;
    ws_pc = 32'h8000_0400; ws_exccode = 5'h0A;
    #1;
    checks++; if ({c0_ex, c0_eret} !== 2'b10) begin errors++; $display("[TB] FAIL eretint_pulse got=%b want=10", {c0_ex, c0_eret}); end
    checks++; if ({c0_exccode, c0_pc} !== {5'h00, 32'h8000_0400}) begin errors++; $display("[TB] FAIL eretint_code_pc got=%h/%h want=00/80000400", c0_exccode, c0_pc); end
    stepCycle();
    clearInputs();
    stepCycle();
    stepCycle();
    checks++; if ({redir_valid, redir_pc} !== {1'b1, VEC}) begin errors++; $display("[TB] FAIL eretint_redir got v=%b pc=%h want v=1 pc=%h", redir_valid, redir_pc, VEC); end
    redir_ready = 1;
    stepCycle();
    redir_ready = 0;
  endtask

  task automatic test_back_to_back();
    ws_valid = 1; ws_ex = 1; ws_exccode = 5'h05; ws_pc = 32'h8000_0200;
    stepCycle();
    ws_exccode = 5'h0C; ws_pc = 32'h8000_0204;
    #1;
    checks++; if ({flush, c0_ex, commit_ok} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_flush_ignore got=%b want=100", {flush, c0_ex, commit_ok}); end
    stepCycle();
    stepCycle();
    int_pending = 8'h01;
    #1;
    checks++; if ({redir_valid, c0_ex, commit_ok} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_redir_ignore got=%b want=100", {redir_valid, c0_ex, commit_ok}); end
`ifdef EXC_SCHED_STAT_EN
    checks++; if (exc_count !== 32'd3) begin errors++; $display("[TB] FAIL b2b_exc_count got=%0d want=3", exc_count); end
`endif
    clearInputs();
    redir_ready = 1;
    stepCycle();
    redir_ready = 0;
  endtask

  task automatic test_no_valid();
    ws_valid = 0; ws_ex = 1; ws_eret = 1; int_pending = 8'hFF;
    #1;
    checks++; if ({c0_ex, c0_eret, commit_ok} !== 3'b001) begin errors++; $display("[TB] FAIL novalid got=%b want=001", {c0_ex, c0_eret, commit_ok}); end
    stepCycle();
    checks++; if ({flush, redir_valid} !== 2'b00) begin errors++; $display("[TB] FAIL novalid_next got=%b want=00", {flush, redir_valid}); end
    clearInputs();
  endtask

  task automatic test_reset_in_redir();
    ws_valid = 1; ws_ex = 1; ws_exccode = 5'h06;
    stepCycle();
    clearInputs();
    stepCycle();
    stepCycle();
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstredir_pre got=%b want=1", redir_valid); end
    reset = 1;
    stepCycle();
    reset = 0;
    #1;
    checks++; if ({redir_valid, flush, commit_ok} !== 3'b001) begin errors++; $display("[TB] FAIL rstredir_post got=%b want=001", {redir_valid, flush, commit_ok}); end
`ifdef EXC_SCHED_STAT_EN
    checks++; if ({exc_count, eret_count} !== 64'h0) begin errors++; $display("[TB] FAIL rstredir_counts got=%h/%h want=0/0", exc_count, eret_count); end
`endif
    stepCycle();
    checks++; if ({redir_valid, commit_ok} !== 2'b01) begin errors++; $display("[TB] FAIL rstredir_idle got=%b want=01", {redir_valid, commit_ok}); end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_redir_stall();
    test_eret();
    test_eret_int();
    test_back_to_back();
    test_no_valid();
    test_reset_in_redir();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
